// File: rtl/ahb_mtx_pkg.sv
// Shared encodings for the bus-matrix input stage: AHB transfer/burst/response
// codes and the input-hold state type.
package ahb_mtx_pkg;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    localparam logic [2:0] BUR_SINGLE = 3'd0;
    localparam logic [2:0] BUR_INCR   = 3'd1;
    localparam logic [2:0] BUR_WRAP4  = 3'd2;
    localparam logic [2:0] BUR_INCR4  = 3'd3;
    localparam logic [2:0] BUR_WRAP8  = 3'd4;
    localparam logic [2:0] BUR_INCR8  = 3'd5;
    localparam logic [2:0] BUR_WRAP16 = 3'd6;
    localparam logic [2:0] BUR_INCR16 = 3'd7;

    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    // ST_IDLE: nothing held, ST_HELD: transfer pending grant,
    // ST_ERR: first cycle of a two-cycle ERROR response was seen
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_ERR  = 2'd2
    } hold_state_t;

endpackage

// File: rtl/ahb_mtx_input_hold_hold_reg.sv
// Capture bank for one master address phase (addr/trans/write/size/burst/prot/lock).
// Loads on load, clears asynchronously to an IDLE transfer.
module ahb_mtx_hold_reg
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr_d,
    input  logic [1:0]            trans_d,
    input  logic                  write_d,
    input  logic [2:0]            size_d,
    input  logic [2:0]            burst_d,
    input  logic [3:0]            prot_d,
    input  logic                  mastlock_d,
    output logic [ADDR_WIDTH-1:0] addr_q,
    output logic [1:0]            trans_q,
    output logic                  write_q,
    output logic [2:0]            size_q,
    output logic [2:0]            burst_q,
    output logic [3:0]            prot_q,
    output logic                  mastlock_q
);

    // Capture the live address-phase controls when the stage must hold them
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q     <= '0;
            trans_q    <= TRN_IDLE;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= BUR_SINGLE;
            prot_q     <= '0;
            mastlock_q <= 1'b0;
        end else if (load) begin
            addr_q     <= addr_d;
            trans_q    <= trans_d;
            write_q    <= write_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            prot_q     <= prot_d;
            mastlock_q <= mastlock_d;
        end
    end

endmodule

// File: rtl/ahb_mtx_input_hold.sv
// Bus-matrix input stage: holds an address phase the output stage could not take,
// replays it until granted while stalling the master, and routes the owning
// output stage's data-phase response back to the master.
// Optional: AHB_MTX_ERR_CANCEL_EN drops a held transfer when the master goes
// IDLE during the second cycle of an ERROR response.
module ahb_mtx_input_hold
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYM,
    input  logic                  dp_active,
    input  logic                  HREADYOUTM,
    input  logic                  HRESPM,
    output logic                  sel_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [1:0]            trans_in,
    output logic                  write_in,
    output logic [2:0]            size_in,
    output logic [2:0]            burst_in,
    output logic [3:0]            prot_in,
    output logic                  mastlock_in,
    output logic                  held_tran,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    hold_state_t state_q, state_d;
    logic        held_d;
    logic        load, accept, err_cycle1, capture;

    logic [ADDR_WIDTH-1:0] h_addr;
    logic [1:0]            h_trans;
    logic                  h_write;
    logic [2:0]            h_size;
    logic [2:0]            h_burst;
    logic [3:0]            h_prot;
    logic                  h_mastlock;

    assign load       = HSELS & HREADYS & HTRANSS[1];
    assign accept     = active_trans & HREADYM;
    assign err_cycle1 = dp_active & (HRESPM == RSP_ERROR) & ~HREADYOUTM;
    // The master is stalled while held, so only a fresh address phase is captured
    assign capture    = load & ~accept & ~held_tran;

    ahb_mtx_hold_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_reg (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load       (capture),
        .addr_d     (HADDRS),
        .trans_d    (HTRANSS),
        .write_d    (HWRITES),
        .size_d     (HSIZES),
        .burst_d    (HBURSTS),
        .prot_d     (HPROTS),
        .mastlock_d (HMASTLOCKS),
        .addr_q     (h_addr),
        .trans_q    (h_trans),
        .write_q    (h_write),
        .size_q     (h_size),
        .burst_q    (h_burst),
        .prot_q     (h_prot),
        .mastlock_q (h_mastlock)
    );

    // State and held flag registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            held_tran <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_tran <= held_d;
        end
    end

    // Next held flag and state; ST_ERR keeps the held flag separately because
    // a transfer may or may not be pending while an ERROR response completes
    always_comb begin
        held_d = held_tran;
        unique case (state_q)
            ST_IDLE: held_d = load & ~accept;
            ST_HELD: held_d = ~accept;
            ST_ERR: begin
                if (held_tran) begin
`ifdef AHB_MTX_ERR_CANCEL_EN
                    held_d = ~accept & (HTRANSS != TRN_IDLE);
`else
                    held_d = ~accept;
`endif
                end else begin
                    held_d = load & ~accept;
                end
            end
            default: held_d = 1'b0;
        endcase
        state_d = err_cycle1 ? ST_ERR : (held_d ? ST_HELD : ST_IDLE);
    end

    // Master response routing and address-phase mux toward the arbiters
    always_comb begin
        HREADYOUTS  = 1'b1;
        HRESPS      = RSP_OKAY;
        sel_in      = 1'b0;
        addr_in     = '0;
        trans_in    = TRN_IDLE;
        write_in    = 1'b0;
        size_in     = '0;
        burst_in    = BUR_SINGLE;
        prot_in     = '0;
        mastlock_in = 1'b0;
        if (dp_active) begin
            HREADYOUTS = HREADYOUTM;
            HRESPS     = HRESPM;
        end else if (held_tran) begin
            HREADYOUTS = 1'b0;
        end
        if (held_tran) begin
            sel_in      = 1'b1;
            addr_in     = h_addr;
            trans_in    = h_trans;
            write_in    = h_write;
            size_in     = h_size;
            burst_in    = h_burst;
            prot_in     = h_prot;
            mastlock_in = h_mastlock;
        end else if (HSELS) begin
            sel_in      = HREADYS;
            addr_in     = HADDRS;
            trans_in    = HTRANSS;
            write_in    = HWRITES;
            size_in     = HSIZES;
            burst_in    = HBURSTS;
            prot_in     = HPROTS;
            mastlock_in = HMASTLOCKS;
        end
    end

endmodule
